// File: rtl/display_pkg.sv
// Shared types and helpers for the seven-segment scan controller.
package display_pkg;

  localparam logic [3:0] CODE_BLANK = 4'b0000;

  typedef enum logic {
    S_GUARD,
    S_DRIVE
  } scan_state_t;

  // The decoder takes an inverted nibble; hex F therefore also reads as blank.
  function automatic logic [3:0] to_code(input logic [3:0] nibble);
    return ~nibble;
  endfunction

endpackage

// File: rtl/display_scan_controller_if.sv
// Producer handshake plus display pins of the scan controller, with the FSM state for observation.
interface display_scan_controller_if
  import display_pkg::*;
#(
    parameter int NUM_DIGITS = 4
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  // load/ready: a transfer happens on every rising edge where load && ready;
  // value/blank_lz must be stable while load is high, ready never depends on load.
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   value;
  logic                      blank_lz;
  logic                      ready;
  logic [3:0]                code;
  logic [NUM_DIGITS-1:0]     an;
  logic [IDX_W-1:0]          digit_idx;
  logic                      frame_done;
  scan_state_t               state;

  modport master(
      output load, value, blank_lz,
      input ready, code, an, digit_idx, frame_done, state
  );

  modport slave(
      input load, value, blank_lz,
      output ready, code, an, digit_idx, frame_done, state
  );

endinterface

// File: rtl/lz_blank_mask.sv
// Leading-zero blank mask: bit i set when digit i and everything above it are zero.
module lz_blank_mask #(
    parameter int NUM_DIGITS = 4
) (
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    blank_lz,
    output logic [NUM_DIGITS-1:0]   mask
);

  logic upper_zero;

  // Digit 0 is never blanked so a zero value still shows "0".
  always_comb begin
    mask       = '0;
    upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      upper_zero = upper_zero && (value[4*i +: 4] == 4'h0);
      mask[i]    = blank_lz && upper_zero;
    end
  end

endmodule

// File: rtl/display_scan_controller.sv
// Multiplexes a double-buffered hex value across common-anode digits with a
// blank guard interval at the start of each digit slot.
module display_scan_controller
  import display_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 500
) (
    input logic                      clk,
    input logic                      rst,
    display_scan_controller_if.slave bus
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int VAL_W = 4 * NUM_DIGITS;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_PRE    = CNT_W'(REFRESH_DIV - 2);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  scan_state_t           state;
  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic [VAL_W-1:0]      active_val, shadow_val;
  logic                  active_blz, shadow_blz;
  logic                  pending, ready_q, frame_done_q;
  logic [3:0]            code_q;
  logic [NUM_DIGITS-1:0] an_q;

  logic                  slot_end, frame_end, swap, accept;
  logic [VAL_W-1:0]      active_val_nxt;
  logic                  active_blz_nxt;
  logic [IDX_W-1:0]      idx_nxt;
  logic [3:0]            nibble_nxt;
  logic [NUM_DIGITS-1:0] blank_mask, drive_an;

  assign slot_end  = (state == S_DRIVE) && (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);
  assign swap      = frame_end && pending;
  assign accept    = bus.load && ready_q;

  // The code latched for the next slot must already see a swap happening this cycle.
  assign active_val_nxt = swap ? shadow_val : active_val;
  assign active_blz_nxt = swap ? shadow_blz : active_blz;
  assign idx_nxt        = !slot_end ? idx : ((idx == IDX_LAST) ? '0 : idx + IDX_W'(1));
  assign nibble_nxt     = active_val_nxt[{idx_nxt, 2'b00} +: 4];

  lz_blank_mask #(
      .NUM_DIGITS(NUM_DIGITS)
  ) u_mask (
      .value   (active_val_nxt),
      .blank_lz(active_blz_nxt),
      .mask    (blank_mask)
  );

  // A blanked digit keeps its anode off for the whole slot.
  assign drive_an = blank_mask[idx] ? '1 : ~(NUM_DIGITS'(1) << idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_GUARD;
      cnt          <= '0;
      idx          <= '0;
      active_val   <= '0;
      active_blz   <= 1'b1;
      shadow_val   <= '0;
      shadow_blz   <= 1'b0;
      pending      <= 1'b0;
      ready_q      <= 1'b1;
      frame_done_q <= 1'b0;
      code_q       <= to_code(4'h0);
      an_q         <= '1;
    end else begin
      active_val   <= active_val_nxt;
      active_blz   <= active_blz_nxt;
      frame_done_q <= (cnt == CNT_PRE) && (idx == IDX_LAST);
      cnt          <= slot_end ? '0 : cnt + CNT_W'(1);

      if (swap) begin
        pending <= 1'b0;
        ready_q <= 1'b1;
      end else if (accept) begin
        shadow_val <= bus.value;
        shadow_blz <= bus.blank_lz;
        pending    <= 1'b1;
        ready_q    <= 1'b0;
      end

      case (state)
        S_GUARD: begin
          if (cnt == GUARD_LAST) begin
            state <= S_DRIVE;
            an_q  <= drive_an;
          end
        end
        S_DRIVE: begin
          if (slot_end) begin
            state  <= S_GUARD;
            an_q   <= '1;
            idx    <= idx_nxt;
            code_q <= blank_mask[idx_nxt] ? CODE_BLANK : to_code(nibble_nxt);
          end
        end
        default: state <= S_GUARD;
      endcase
    end
  end

  assign bus.ready      = ready_q;
  assign bus.code       = code_q;
  assign bus.an         = an_q;
  assign bus.digit_idx  = idx;
  assign bus.frame_done = frame_done_q;
  assign bus.state      = state;

endmodule

// File: tb/tb_display_scan_controller.sv
// Scoreboard bench: a per-cycle reference model pushes expected pin values, a negedge monitor compares.
module tb_display_scan_controller;
  import display_pkg::*;

  localparam int N     = 4;
  localparam int R     = 8;
  localparam int G     = 2;
  localparam int FRAME = N * R;

  logic clk;
  logic rst;

  display_scan_controller_if #(.NUM_DIGITS(N)) bus ();

  display_scan_controller #(
      .NUM_DIGITS (N),
      .REFRESH_DIV(R),
      .GUARD      (G)
  ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  logic [11:0] exp_q[$];
  int          t_q[$];
  int          n_checks;
  int          n_fail;
  logic        mon_en;
  logic        prev_valid;
  logic [3:0]  prev_code;

  // reference model: time since reset release and the buffers as seen by a user
  int          m_t;
  logic [15:0] m_disp, m_shadow;
  logic        m_disp_blz, m_shadow_blz, m_pending;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_init();
    m_t          = 0;
    m_disp       = 16'h0000;
    m_disp_blz   = 1'b1;
    m_shadow     = 16'h0000;
    m_shadow_blz = 1'b0;
    m_pending    = 1'b0;
  endtask

  // Expected pins for the current cycle, then the buffer effect of this cycle's inputs.
  task automatic model_push(input logic ld, input logic [15:0] v, input logic bz);
    int          slot, dig;
    logic [15:0] upper;
    logic        blank, fd, old_pend;
    logic [3:0]  code, an;
    slot  = m_t % R;
    dig   = (m_t / R) % N;
    upper = m_disp >> (4 * dig);
    blank = (dig != 0) && m_disp_blz && (upper == 16'h0000);
    code  = blank ? 4'b0000 : ~upper[3:0];
    an    = (slot < G || blank) ? 4'b1111 : ~(4'b0001 << dig);
    fd    = (m_t % FRAME) == FRAME - 1;
    exp_q.push_back({fd, ~m_pending, 2'(dig), an, code});
    t_q.push_back(m_t);
    old_pend = m_pending;
    if (fd && old_pend) begin
      m_disp     = m_shadow;
      m_disp_blz = m_shadow_blz;
      m_pending  = 1'b0;
    end
    if (ld && !old_pend) begin
      m_shadow     = v;
      m_shadow_blz = bz;
      m_pending    = 1'b1;
    end
    m_t++;
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; drives one full cycle of inputs.
  task automatic run_cycle(input logic ld, input logic [15:0] v, input logic bz);
    bus.load     = ld;
    bus.value    = v;
    bus.blank_lz = bz;
    model_push(ld, v, bz);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) run_cycle(1'b0, 16'h0000, 1'b0);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 4 * FRAME && m_pending; i++) idle(1);
    check("wait_ready_timeout", {31'd0, m_pending}, 32'd0);
  endtask

  task automatic do_reset();
    mon_en   = 1'b0;
    rst      = 1'b1;
    bus.load = 1'b0;
    #1;
    check("rst_an", {28'd0, bus.an}, 32'hF);
    check("rst_code", {28'd0, bus.code}, 32'hF);
    check("rst_ready", {31'd0, bus.ready}, 32'd1);
    check("rst_frame_done", {31'd0, bus.frame_done}, 32'd0);
    check("rst_digit_idx", {30'd0, bus.digit_idx}, 32'd0);
    check("rst_state", {31'd0, bus.state}, {31'd0, S_GUARD});
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_init();
    exp_q.delete();
    t_q.delete();
    mon_en = 1'b1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!mon_en) begin
      prev_valid <= 1'b0;
    end else begin
      if (exp_q.size() == 0) begin
        check("scoreboard_underflow", 32'd1, 32'd0);
      end else begin
        logic [11:0] e;
        int t;
        e = exp_q.pop_front();
        t = t_q.pop_front();
        check($sformatf("scan t=%0d {fd,rdy,idx,an,code}", t),
              {20'd0, bus.frame_done, bus.ready, bus.digit_idx, bus.an, bus.code}, {20'd0, e});
      end
      n_checks++;
      if ($countones(~bus.an) > 1) begin
        n_fail++;
        $display("FAIL an_onehot: got an=%b, expected at most one low bit", bus.an);
      end
      if (bus.an != 4'b1111 && prev_valid)
        check("code_stable_while_lit", {28'd0, bus.code}, {28'd0, prev_code});
      prev_code  <= bus.code;
      prev_valid <= 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic        ld, bz;
    logic [15:0] v;
    n_checks     = 0;
    n_fail       = 0;
    mon_en       = 1'b0;
    prev_valid   = 1'b0;
    prev_code    = 4'h0;
    rst          = 1'b0;
    bus.load     = 1'b0;
    bus.value    = 16'h0000;
    bus.blank_lz = 1'b0;
    model_init();
    #2;
    do_reset();

    // idle frame shows "0" on digit 0 only
    idle(FRAME);

    // full value, no blanking, then ignored loads while the shadow is full
    run_cycle(1'b1, 16'h1A3F, 1'b0);
    for (int i = 0; i < 8; i++) run_cycle(1'b1, 16'h5555 ^ 16'(i), 1'b1);
    idle(2 * FRAME + 8);

    // leading-zero blanking
    wait_ready();
    run_cycle(1'b1, 16'h0070, 1'b1);
    idle(2 * FRAME + 8);

    // load exactly on the frame_done cycle: swap waits a whole frame
    for (int i = 0; i < 4 * FRAME && !((m_t % FRAME) == FRAME - 1 && !m_pending); i++) idle(1);
    check("frame_end_reached", {31'd0, ((m_t % FRAME) == FRAME - 1 && !m_pending)}, 32'd1);
    run_cycle(1'b1, 16'hBEEF, 1'b0);
    idle(2 * FRAME + 8);

    // randomized traffic, biased towards values with leading zeros
    for (int i = 0; i < 600; i++) begin
      ld = ($urandom_range(0, 7) == 0);
      v  = 16'($urandom) >> (4 * $urandom_range(0, 3));
      bz = 1'($urandom_range(0, 1));
      run_cycle(ld, v, bz);
    end

    // reset in the middle of digit 2's drive phase
    wait_ready();
    run_cycle(1'b1, 16'h4321, 1'b0);
    idle(2 * FRAME);
    for (int i = 0; i < 2 * FRAME && (m_t % FRAME) != 2 * R + G + 2; i++) idle(1);
    mon_en = 1'b0;
    check("pre_reset_an", {28'd0, bus.an}, 32'hB);
    bus.load = 1'b1;
    bus.value = 16'h9999;
    #2;
    do_reset();
    idle(FRAME + 8);

    mon_en = 1'b0;
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/display_scan_controller.md
# display_scan_controller

Time-multiplexes the shared active-low seven-segment decoder across `NUM_DIGITS` common-anode digits of the multiplier result display. It holds a double-buffered hex value, steps through the digits at a fixed refresh rate, and drives the decoder's inverted nibble input and the active-low anode enables. A guard interval with all anodes off separates consecutive digits to prevent ghosting. It sits between the multiplier datapath (`load`/`ready` producer side) and the decoder/anode pins.

## Interface
- `NUM_DIGITS`, 4: digits scanned; legal range 2..8.
- `REFRESH_DIV`, 50000: clock cycles per digit slot; must be > `GUARD`.
- `GUARD`, 500: cycles at the start of each slot with all anodes off; must be ≥ 1.
- `clk` in 1: single system clock; all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `load` in 1: producer offers `value`/`blank_lz`; accepted only when `ready`=1.
- `value` in 4*NUM_DIGITS: hex digits; `[3:0]` is digit 0 (least significant).
- `blank_lz` in 1: enable leading-zero blanking for the offered value.
- `ready` out 1: shadow buffer empty; a `load` is accepted this cycle.
- `code` out 4: decoder input; `~digit` for a shown digit, `4'b0000` for blank.
- `an` out NUM_DIGITS: anode enables, active-low, at most one bit low.
- `digit_idx` out clog2(NUM_DIGITS): digit currently selected.
- `frame_done` out 1: one-cycle pulse on the last cycle of each frame.

## Operation
- Registers: `active` (value + blank_lz shown), `shadow` (pending), `pending` flag, slot counter `cnt` (0..REFRESH_DIV-1), `digit_idx`, and a 2-state FSM.
- FSM `S_GUARD`: `an` = all ones, `code` = code of `digit_idx`. After `GUARD` cycles go to `S_DRIVE`.
- FSM `S_DRIVE`: `an[digit_idx]`=0 and all others 1. When `cnt`=REFRESH_DIV-1, go to `S_GUARD` with `digit_idx`+1 and `cnt`=0. `digit_idx` wraps from NUM_DIGITS-1 to 0.
- Frame end is the `S_DRIVE` cycle with `cnt`=REFRESH_DIV-1 and `digit_idx`=NUM_DIGITS-1. On that cycle `frame_done`=1 and, if `pending` was already set, `active`←`shadow` and `pending`←0.
- Load handshake: `load`&&`ready` sets `shadow`←{`value`,`blank_lz`} and `pending`←1. `ready` = `~pending`, a registered flag. `load` while `ready`=0 is ignored and leaves `shadow` unchanged.
- Simultaneous load and frame end with `pending`=0: the value is captured but not swapped. The swap happens at the next frame end.
- Leading-zero blanking: when `active.blank_lz`=1, digit i (i≥1) is blank iff digits i..NUM_DIGITS-1 are all 0. Digit 0 is never blank.
- Hex F: `~F`=`0000`, which the decoder shows as blank. This is accepted behaviour, and the block does not special-case F.
- Reset (async, any state, mid-slot included) forces these values immediately:
  - `an` all ones, `code`=`4'b1111` (digit "0"), `digit_idx`=0, `cnt`=0, FSM=`S_GUARD`.
  - `ready`=1, `pending`=0, `frame_done`=0.
  - `active` value 0 with `blank_lz`=1, so "0" shows on digit 0 only; `shadow`=0.

## Timing
- Slot = `REFRESH_DIV` cycles: `GUARD` blank cycles, then `REFRESH_DIV-GUARD` drive cycles. Frame = NUM_DIGITS*REFRESH_DIV cycles.
- First anode goes low `GUARD` cycles after reset deasserts.
- `code` changes only on the first cycle of `S_GUARD`, never while any anode is low.
- All outputs are registered, with no combinational path from inputs to outputs.
- `ready` falls the cycle after acceptance and rises the cycle after the swap.
- Load-to-display latency is at most 2 frames plus `GUARD` cycles.

## Structure
- Shared package `display_pkg` holds:
  - `CODE_BLANK`=`4'b0000`;
  - function `to_code(nibble)` = `~nibble`;
  - the FSM state typedef {`S_GUARD`,`S_DRIVE`}.
- Sub-module `lz_blank_mask`: combinational; maps (`active` value, `blank_lz`) to a NUM_DIGITS blank mask.
- Everything else is one module: counter, FSM, buffers and output registers.

## Test plan
- Bench parameters for all scenarios: NUM_DIGITS=4, REFRESH_DIV=8, GUARD=2.
- Reset, then run 1 frame → `an` sequence per slot: 1111×2, 1110×6; then 1111×2, then 1111×6 for blanked digits 1–3 (anode off), and so on. `code`=1111 in slot 0. `frame_done` pulses once, at cycle 31 after reset release.
- Load `value`=16'h1A3F with `blank_lz`=0 → `ready` drops next cycle. After the frame end, the `code` per slot is 0000, 1100, 0101, 1110 (digits F,3,A,1) and `ready` returns to 1.
- Load 16'h0070 with `blank_lz`=1 → digits 3 and 2 are blank (`code` 0000, `an` all 1 in those slots). Digit 1 shows `code`=1000 and digit 0 shows `code`=1111.
- Load during `ready`=0 with a different value → ignored; the first value is displayed. Load on the frame_done cycle → swap is delayed exactly one frame.
- Assert `rst` mid-`S_DRIVE` of digit 2 → same cycle: `an`=1111, `ready`=1, `pending`=0. After release, the scan restarts at digit 0 and shows "0".
- Throughout: assert at most one `an` bit is low, and `code` is stable whenever any `an` bit is low.
